logic_unit_pipe: RTL and testbench

Parametrised, pipelined successor to the team's single-register logic unit. It performs eight bitwise functions on two operands through a two-stage pipeline with valid/ready handshakes on both the input and output sides. It also registers zero and parity flags alongside the result. It sits behind the ALU decode stage, and its output drains into the ALU result mux.

---
 rtl/logic_unit_pipe.sv | 183 ++++++++++++++++++
 tb/tb_logic_unit_pipe.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
//   Two-stage pipelined bitwise logic unit with valid/ready handshakes on both
//   sides. Stage A holds the (width-adjusted) operands and function code;
//   stage B holds the result plus zero and parity flags.
//
// Parameters
//   IN1_WIDTH        width of operand in1
//   IN2_WIDTH        width of operand in2
//   LOGIC_OUT_WIDTH  result width W; operands are zero-extended or truncated
//                    (LSBs kept) to W
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   logic_en     in   unit enable, gates input acceptance only
//   in_valid     in   operand beat offered
//   in_ready     out  unit can accept a beat (combinational)
//   in1, in2     in   operands
//   logic_fun    in   function select (AND/OR/XOR/XNOR/NAND/NOR/NOT in1/in2)
//   out_ready    in   downstream accepts a result
//   logic_out    out  registered result
//   logic_flag   out  result valid
//   zero_flag    out  logic_out == 0
//   parity_flag  out  XOR-reduce of logic_out
// -----------------------------------------------------------------------------
module logic_unit_pipe #(
   parameter int IN1_WIDTH       = 16,
   parameter int IN2_WIDTH       = 16,
   parameter int LOGIC_OUT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       logic_en,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [IN1_WIDTH-1:0]       in1,
   input  logic [IN2_WIDTH-1:0]       in2,
   input  logic [2:0]                 logic_fun,
   input  logic                       out_ready,
   output logic [LOGIC_OUT_WIDTH-1:0] logic_out,
   output logic                       logic_flag,
   output logic                       zero_flag,
   output logic                       parity_flag
);

   localparam int W = LOGIC_OUT_WIDTH;

   // Bitwise function table
   function automatic logic [W-1:0] logic_fn(input logic [2:0]   fun,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
      logic [W-1:0] r;
      r = {W{1'b0}};
      case (fun)
         3'b000:  r = a & b;
         3'b001:  r = a | b;
         3'b010:  r = a ^ b;
         3'b011:  r = ~(a ^ b);
         3'b100:  r = ~(a & b);
         3'b101:  r = ~(a | b);
         3'b110:  r = ~a;
         3'b111:  r = b;
         default: r = {W{1'b0}};
      endcase
      return r;
   endfunction

   // Even-parity helper: 1 when the vector holds an odd number of ones
   function automatic logic parity_fn(input logic [W-1:0] v);
      return ^v;
   endfunction

   logic [W-1:0] in1_ext_s;
   logic [W-1:0] in2_ext_s;

   // Width adaptation happens at the input so stage A always holds W bits
   generate
      if (IN1_WIDTH >= W) begin : g_in1_trunc
         assign in1_ext_s = in1[W-1:0];
      end else begin : g_in1_zext
         assign in1_ext_s = {{(W-IN1_WIDTH){1'b0}}, in1};
      end
      if (IN2_WIDTH >= W) begin : g_in2_trunc
         assign in2_ext_s = in2[W-1:0];
      end else begin : g_in2_zext
         assign in2_ext_s = {{(W-IN2_WIDTH){1'b0}}, in2};
      end
   endgenerate

   // Stage A (operands) and stage B (result) state
   logic         a_valid_q, a_valid_d;
   logic [W-1:0] a_in1_q,   a_in1_d;
   logic [W-1:0] a_in2_q,   a_in2_d;
   logic [2:0]   a_fun_q,   a_fun_d;
   logic         b_valid_q, b_valid_d;
   logic [W-1:0] b_out_q,   b_out_d;
   logic         b_zero_q,  b_zero_d;
   logic         b_par_q,   b_par_d;

   logic         b_load_s;
   logic         a_ready_s;
   logic         accept_s;
   logic [W-1:0] res_s;

   // Handshake: B refills whenever it is empty or being drained this cycle,
   // and A frees up in the same cycle it hands off to B, so a full pipeline
   // passes out_ready straight through to in_ready.
   always_comb begin
      b_load_s  = a_valid_q & (~b_valid_q | out_ready);
      a_ready_s = ~a_valid_q | b_load_s;
      accept_s  = in_valid & logic_en & a_ready_s;
      res_s     = logic_fn(a_fun_q, a_in1_q, a_in2_q);
   end

   assign in_ready = logic_en & a_ready_s;

   // Stage A next state: load on accept, empty when handed off with no refill
   always_comb begin
      a_valid_d = a_valid_q;
      a_in1_d   = a_in1_q;
      a_in2_d   = a_in2_q;
      a_fun_d   = a_fun_q;
      if (accept_s) begin
         a_valid_d = 1'b1;
         a_in1_d   = in1_ext_s;
         a_in2_d   = in2_ext_s;
         a_fun_d   = logic_fun;
      end else if (b_load_s) begin
         a_valid_d = 1'b0;
      end else begin
         a_valid_d = a_valid_q;
      end
   end

   // Stage B next state: take f(A) on load; otherwise a consumed result
   // with nothing behind it clears the valid flag, else everything holds.
   always_comb begin
      b_valid_d = b_valid_q;
      b_out_d   = b_out_q;
      b_zero_d  = b_zero_q;
      b_par_d   = b_par_q;
      if (b_load_s) begin
         b_valid_d = 1'b1;
         b_out_d   = res_s;
         b_zero_d  = (res_s == {W{1'b0}});
         b_par_d   = parity_fn(res_s);
      end else if (out_ready) begin
         b_valid_d = 1'b0;
      end else begin
         b_valid_d = b_valid_q;
      end
   end

   // Pipeline registers; reset flushes both stages
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_valid_q <= 1'b0;
         a_in1_q   <= {W{1'b0}};
         a_in2_q   <= {W{1'b0}};
         a_fun_q   <= 3'b000;
         b_valid_q <= 1'b0;
         b_out_q   <= {W{1'b0}};
         b_zero_q  <= 1'b0;
         b_par_q   <= 1'b0;
      end else begin
         a_valid_q <= a_valid_d;
         a_in1_q   <= a_in1_d;
         a_in2_q   <= a_in2_d;
         a_fun_q   <= a_fun_d;
         b_valid_q <= b_valid_d;
         b_out_q   <= b_out_d;
         b_zero_q  <= b_zero_d;
         b_par_q   <= b_par_d;
      end
   end

   assign logic_out   = b_out_q;
   assign logic_flag  = b_valid_q;
   assign zero_flag   = b_zero_q;
   assign parity_flag = b_par_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_pipe
//   Self-checking bench for logic_unit_pipe. A behavioural model (queue of
//   in-flight results, each marked visible once it has reached the output)
//   is compared against the DUT on every falling edge; directed sequences add
//   hand-computed literal expectations. A second instance checks the
//   width-adaptation parameters.
// -----------------------------------------------------------------------------
module tb_logic_unit_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        logic_en;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in1;
   logic [15:0] in2;
   logic [2:0]  logic_fun;
   logic        out_ready;
   logic [15:0] logic_out;
   logic        logic_flag;
   logic        zero_flag;
   logic        parity_flag;

   logic        w_valid;
   logic        w_ready;
   logic [7:0]  w_in1;
   logic [19:0] w_in2;
   logic [2:0]  w_fun;
   logic [11:0] w_out;
   logic        w_flag;
   logic        w_zero;
   logic        w_par;

   logic_unit_pipe dut (
      .clk(clk), .rst(rst), .logic_en(logic_en), .in_valid(in_valid),
      .in_ready(in_ready), .in1(in1), .in2(in2), .logic_fun(logic_fun),
      .out_ready(out_ready), .logic_out(logic_out), .logic_flag(logic_flag),
      .zero_flag(zero_flag), .parity_flag(parity_flag)
   );

   logic_unit_pipe #(.IN1_WIDTH(8), .IN2_WIDTH(20), .LOGIC_OUT_WIDTH(12)) dut_w (
      .clk(clk), .rst(rst), .logic_en(1'b1), .in_valid(w_valid),
      .in_ready(w_ready), .in1(w_in1), .in2(w_in2), .logic_fun(w_fun),
      .out_ready(1'b1), .logic_out(w_out), .logic_flag(w_flag),
      .zero_flag(w_zero), .parity_flag(w_par)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] ref_fn(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] f);
      case (f)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~(a ^ b);
         3'd4:    return ~(a & b);
         3'd5:    return ~(a | b);
         3'd6:    return ~a;
         default: return b;
      endcase
   endfunction

   // Model: ordered in-flight results; at most two (operand slot + output slot).
   typedef struct {
      logic [15:0] res;
      bit          vis;
   } item_t;
   item_t mq[$];

   task automatic model_step(input bit acc, input logic [15:0] r);
      if (mq.size() > 0 && mq[0].vis && out_ready) void'(mq.pop_front());
      if (mq.size() > 0 && !mq[0].vis) mq[0].vis = 1'b1;
      if (acc) mq.push_back('{res: r, vis: 1'b0});
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) mq.delete();
      else model_step(in_valid && logic_en && (mq.size() < 2 || out_ready),
                      ref_fn(in1, in2, logic_fun));
   end

   // Compare process: every cycle away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready", in_ready, logic_en && (mq.size() < 2 || out_ready));
         check("logic_flag", logic_flag, (mq.size() > 0) ? mq[0].vis : 1'b0);
         if (mq.size() > 0 && mq[0].vis) begin
            check("logic_out", logic_out, mq[0].res);
            check("zero_flag", zero_flag, mq[0].res == 16'h0000);
            check("parity_flag", parity_flag, ^mq[0].res);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic [2:0] f);
      in_valid  = 1'b1;
      in1       = a;
      in2       = b;
      logic_fun = f;
   endtask

   logic [15:0] sweep_tbl [8];
   logic [15:0] ba [4];
   logic [15:0] bb [4];
   logic [2:0]  bf [4];
   logic [15:0] prev;

   initial begin
      sweep_tbl = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'hF00F,
                    16'h0FFF, 16'h000F, 16'h0F0F, 16'hFF00};
      rst = 1'b0; logic_en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in1 = 16'h0000; in2 = 16'h0000; logic_fun = 3'b000;
      w_valid = 1'b0; w_in1 = 8'h00; w_in2 = 20'h00000; w_fun = 3'b000;
      #1;
      check("rst_flag", logic_flag, 1'b0);
      check("rst_out", logic_out, 16'h0000);
      check("rst_zero", zero_flag, 1'b0);
      check("rst_par", parity_flag, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      logic_en = 1'b0;
      #1;
      check("rst_in_ready_en0", in_ready, 1'b0);
      logic_en = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;
      step();
      rst = 1'b1;

      // Basic function with latency
      beat(16'h000B, 16'h0009, 3'b000);
      step();
      check("basic_lat", logic_flag, 1'b0);
      logic_fun = 3'b001;
      step();
      check("basic_and", logic_out, 16'h0009);
      check("basic_and_par", parity_flag, 1'b0);
      check("basic_and_zero", zero_flag, 1'b0);
      in_valid = 1'b0;
      step();
      check("basic_or", logic_out, 16'h000B);
      check("basic_or_par", parity_flag, 1'b1);

      // Full function sweep, streamed
      for (int i = 0; i < 10; i++) begin
         if (i < 8) beat(16'hF0F0, 16'hFF00, 3'(i));
         else in_valid = 1'b0;
         step();
         if (i >= 1 && i <= 8) check("sweep", logic_out, sweep_tbl[i-1]);
      end

      // Zero result
      beat(16'hAAAA, 16'h5555, 3'b000);
      step();
      in_valid = 1'b0;
      step();
      check("zero_out", logic_out, 16'h0000);
      check("zero_flag1", zero_flag, 1'b1);
      check("zero_par", parity_flag, 1'b0);
      step();

      // Back-pressure
      for (int k = 0; k < 4; k++) begin
         ba[k] = 16'($urandom); bb[k] = 16'($urandom); bf[k] = 3'($urandom_range(0, 7));
      end
      out_ready = 1'b0;
      beat(ba[0], bb[0], bf[0]);
      step();
      beat(ba[1], bb[1], bf[1]);
      step();
      check("bp_full_ready", in_ready, 1'b0);
      check("bp_hold0", logic_out, ref_fn(ba[0], bb[0], bf[0]));
      beat(ba[2], bb[2], bf[2]);
      step();
      step();
      check("bp_still_full", in_ready, 1'b0);
      check("bp_hold1", logic_out, ref_fn(ba[0], bb[0], bf[0]));
      out_ready = 1'b1;
      #1;
      check("bp_ready_same_cycle", in_ready, 1'b1);
      step();
      check("bp_r1", logic_out, ref_fn(ba[1], bb[1], bf[1]));
      beat(ba[3], bb[3], bf[3]);
      step();
      check("bp_r2", logic_out, ref_fn(ba[2], bb[2], bf[2]));
      in_valid = 1'b0;
      step();
      check("bp_r3", logic_out, ref_fn(ba[3], bb[3], bf[3]));
      step();
      check("bp_drained", logic_flag, 1'b0);

      // Enable gating with in-flight beats
      out_ready = 1'b0;
      beat(16'h1234, 16'h00FF, 3'b010);
      step();
      beat(16'h8001, 16'h7FFE, 3'b001);
      step();
      logic_en = 1'b0;
      beat(16'hFFFF, 16'hFFFF, 3'b000);
      out_ready = 1'b1;
      #1;
      check("en0_ready", in_ready, 1'b0);
      step();
      check("en0_drain1", logic_out, 16'hFFFF);
      step();
      step();
      check("en0_empty", logic_flag, 1'b0);
      logic_en = 1'b1;
      in_valid = 1'b0;

      // Throughput: one beat and one result per cycle
      for (int j = 0; j < 10; j++) begin
         beat(16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)));
         step();
         if (j >= 1) begin
            check("tput_flag", logic_flag, 1'b1);
            check("tput_out", logic_out, prev);
         end
         prev = ref_fn(in1, in2, logic_fun);
      end
      in_valid = 1'b0;
      step();
      step();

      // Reset mid-stream with both stages full
      out_ready = 1'b0;
      beat(16'h00F0, 16'h0F00, 3'b001);
      step();
      beat(16'h1111, 16'h2222, 3'b001);
      step();
      in_valid = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      check("mrst_flag", logic_flag, 1'b0);
      check("mrst_out", logic_out, 16'h0000);
      check("mrst_zero", zero_flag, 1'b0);
      check("mrst_ready", in_ready, 1'b1);
      #1;
      rst = 1'b1;
      out_ready = 1'b1;
      beat(16'h5A5A, 16'h0F0F, 3'b010);
      step();
      check("mrst_lat", logic_flag, 1'b0);
      in_valid = 1'b0;
      step();
      check("mrst_res_flag", logic_flag, 1'b1);
      check("mrst_res", logic_out, 16'h5555);
      step();

      // Width parameters on the second instance
      w_valid = 1'b1; w_in1 = 8'hFF; w_in2 = 20'hFFFFF; w_fun = 3'b001;
      step();
      w_valid = 1'b0;
      check("w_lat", w_flag, 1'b0);
      step();
      check("w_or_flag", w_flag, 1'b1);
      check("w_or", w_out, 12'hFFF);
      check("w_or_par", w_par, 1'b0);
      w_valid = 1'b1; w_fun = 3'b110;
      step();
      w_valid = 1'b0;
      step();
      check("w_not", w_out, 12'hF00);
      check("w_not_zero", w_zero, 1'b0);

      // Randomized traffic checked by the model
      for (int c = 0; c < 400; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in1       = 16'($urandom);
         in2       = ($urandom_range(0, 7) == 0) ? ~in1 : 16'($urandom);
         logic_fun = 3'($urandom_range(0, 7));
         logic_en  = ($urandom_range(0, 7) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      in_valid = 1'b0; logic_en = 1'b1; out_ready = 1'b1;
      step();
      step();
      step();
      check("final_drain", logic_flag, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
